// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for a byte-addressed, little-endian data memory.
// Accepts one lw/sw request at a time through valid/ready. Drives the memory
// addr/data/MemRead/MemWrite strobes and waits out the read latency. Returns exactly
// one response per request: load data, store completion, or an error.
// Ports:
//   clk_i, rst_i (async, active-low)
//   req_valid_i/req_ready_o/req_we_i/req_addr_i/req_wdata_i : request from the pipeline
//   rsp_valid_o/rsp_rdata_o/rsp_err_o                       : response to the pipeline
//   stall_o                                                 : freezes upstream stages
//   mem_addr_o/mem_data_o/mem_read_o/mem_write_o/mem_data_i : data memory port
module load_store_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic              rd_d, wr_d;
  logic              rsp_valid_d, rsp_err_d;
  logic              bad_addr;

  // Misaligned or beyond the last full word of memory.
  assign bad_addr = (req_addr_i[1:0] != 2'b00) || (req_addr_i > MAX_ADDR);

  // Ready is masked by reset so no accept can be signalled while reset is held.
  assign req_ready_o = (state_q == IDLE) && rst_i;

  // Stall drops in DONE so the pipeline advances together with the response.
  assign stall_o = ((state_q == IDLE) && req_valid_i) || (state_q == ISSUE) || (state_q == WAIT);

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_addr_o  <= addr_d;
      mem_data_o  <= wdata_d;
      mem_read_o  <= rd_d;
      mem_write_o <= wr_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_err_o   <= rsp_err_d;
      rsp_rdata_o <= rdata_d;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    addr_d      = mem_addr_o;
    wdata_d     = mem_data_o;
    rdata_d     = rsp_rdata_o;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (bad_addr) begin
            // Rejected requests skip the memory entirely.
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rdata_d     = '0;
          end else begin
            state_d = ISSUE;
            wr_d    = req_we_i;
            rd_d    = ~req_we_i;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end
      WAIT: begin
        // Read data is valid in the last WAIT cycle (counter == 1).
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          rdata_d     = mem_data_i;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
